// File: rtl/conv_pkg.sv
// Shared constants for the convolutional layer datapath.
// Default image geometry, filter size and pixel width.
package conv_pkg;

    localparam int DEF_IMG_WIDTH  = 28;
    localparam int DEF_IMG_HEIGHT = 28;
    localparam int DEF_K          = 3;
    localparam int DEF_I_WIDTH    = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sliding_window_unit_if.sv
// Pixel stream in, packed K x K window stream out.
// The slave side is the window unit, the master side feeds and drains it.
interface sliding_window_unit_if #(
    parameter int I_WIDTH = conv_pkg::DEF_I_WIDTH,
    parameter int K       = conv_pkg::DEF_K
);
    import conv_pkg::*;

    logic [I_WIDTH-1:0]     in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [I_WIDTH*K*K-1:0] window_data;
    logic                   window_valid;
    logic                   window_ready;
    logic                   frame_done;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output window_data,
        output window_valid,
        input  window_ready,
        output frame_done
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  window_data,
        input  window_valid,
        output window_ready,
        input  frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image row of delay: an enable-gated shift register.
// Contents are not reset; they are always refilled before use.
module line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int I_WIDTH   = DEF_I_WIDTH
) (
    input  logic               clk,
    input  logic               en,
    input  logic [I_WIDTH-1:0] d,
    output logic [I_WIDTH-1:0] q
);

    logic [I_WIDTH-1:0] mem [IMG_WIDTH];

    // Shift one entry per accepted pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= d;
            for (int i = 1; i < IMG_WIDTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign q = mem[IMG_WIDTH-1];

endmodule

// File: rtl/sliding_window_unit.sv
// Raster pixel stream to stride-1, no-padding K x K windows.
// K-1 line buffers supply the upper rows of each new window column.
module sliding_window_unit
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int K          = DEF_K,
    parameter int I_WIDTH    = DEF_I_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    sliding_window_unit_if.slave bus
);

    localparam int CW = cnt_bits(IMG_WIDTH);
    localparam int RW = cnt_bits(IMG_HEIGHT);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               window_valid;
    logic               frame_done;
    logic               accept;
    logic               last_col;
    logic               last_row;
    logic               win_pos;
    logic [I_WIDTH-1:0] lb_out  [K-1];
    logic [I_WIDTH-1:0] new_col [K];
    logic [I_WIDTH-1:0] win     [K][K];

    assign bus.in_ready     = !window_valid || bus.window_ready;
    assign bus.window_valid = window_valid;
    assign bus.frame_done   = frame_done;

    assign accept   = bus.in_valid && bus.in_ready;
    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));
    assign win_pos  = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

    // Chain of row delays: buffer i outputs the pixel i+1 rows above.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        if (i == 0) begin : g_first
            line_buffer #(
                .IMG_WIDTH (IMG_WIDTH),
                .I_WIDTH   (I_WIDTH)
            ) u_lb (
                .clk (clk),
                .en  (accept),
                .d   (bus.in_data),
                .q   (lb_out[i])
            );
        end else begin : g_next
            line_buffer #(
                .IMG_WIDTH (IMG_WIDTH),
                .I_WIDTH   (I_WIDTH)
            ) u_lb (
                .clk (clk),
                .en  (accept),
                .d   (lb_out[i-1]),
                .q   (lb_out[i])
            );
        end
    end

    // New rightmost column: oldest row on top, incoming pixel at bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = lb_out[K-2-r];
        end
        new_col[K-1] = bus.in_data;
    end

    // Window shifts left by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= new_col[r];
            end
        end
    end

    // Flatten the window, element (r,c) at slot r*K+c.
    always_comb begin
        bus.window_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                bus.window_data[I_WIDTH*(r*K+c) +: I_WIDTH] = win[r][c];
            end
        end
    end

    // Raster position, window valid flag and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (accept && win_pos) begin
                window_valid <= 1'b1;
            end else if (bus.window_ready) begin
                window_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_unit.sv
// Directed bench: 5x4 image, 3x3 window, 8-bit pixels.
// Pixel value is its raster index plus 100 per frame.
module tb_sliding_window_unit;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int KK = 3;
    localparam int IW = 8;
    localparam int NP = W * H;
    localparam int NW = (H - KK + 1) * (W - KK + 1);
    localparam int WC = W - KK + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    sliding_window_unit_if #(.I_WIDTH(IW), .K(KK)) bus ();

    sliding_window_unit #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .K          (KK),
        .I_WIDTH    (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [71:0] obs,
                       input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected window number w of a stream of back-to-back frames.
    function automatic logic [71:0] exp_win(input int w);
        logic [71:0] v;
        int f, i, wr, wc;
        v  = '0;
        f  = w / NW;
        i  = w % NW;
        wr = i / WC;
        wc = i % WC;
        for (int r = 0; r < KK; r++) begin
            for (int c = 0; c < KK; c++) begin
                v[IW*(r*KK+c) +: IW] =
                    IW'(f * 100 + (wr + r) * W + wc + c);
            end
        end
        return v;
    endfunction

    // Stream nf frames; optional input gaps and a 4-cycle stall.
    task automatic run(input int nf, input bit gaps, input bit stall);
        int p, w, fd, st, cyc, np, nw;
        bit acc, xfer;
        p = 0; w = 0; fd = 0; st = 0; cyc = 0;
        np = nf * NP;
        nw = nf * NW;
        while ((p < np || w < nw) && cyc < 400) begin
            bus.in_valid = (p < np) &&
                !(gaps && $urandom_range(0, 2) == 0);
            bus.in_data = IW'((p / NP) * 100 + p % NP);
            bus.window_ready = !(stall && w == 0 &&
                bus.window_valid && st < 4);
            #1;
            if (!bus.window_ready) begin
                st++;
                chk("stall_in_ready", 72'(bus.in_ready), 72'(0));
                chk("stall_hold", 72'(bus.window_data), exp_win(0));
            end
            if (bus.frame_done) begin
                chk("fd_with_valid", 72'(bus.window_valid), 72'(1));
                chk("fd_position", 72'(p), 72'(NP * (fd + 1)));
                fd++;
            end
            xfer = bus.window_valid && bus.window_ready;
            if (xfer) begin
                if (w == 0 && !gaps && !stall)
                    chk("first_win_pos", 72'(p), 72'(13));
                chk("win_in_range", 72'(w < nw), 72'(1));
                if (w < nw)
                    chk("win_data", 72'(bus.window_data), exp_win(w));
                w++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) p++;
            cyc++;
            @(negedge clk);
        end
        chk("no_timeout", 72'(cyc < 400), 72'(1));
        chk("win_count", 72'(w), 72'(nw));
        chk("fd_count", 72'(fd), 72'(nf));
        if (stall) chk("stall_cycles", 72'(st), 72'(4));
        bus.in_valid = 1'b0;
        bus.window_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_win", 72'(bus.window_valid), 72'(0));
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.window_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 72'(bus.window_valid), 72'(0));
        chk("rst_fd", 72'(bus.frame_done), 72'(0));
        chk("rst_in_ready", 72'(bus.in_ready), 72'(1));
        rst = 1'b0;
        @(negedge clk);

        run(1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1);
        run(1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = IW'(200 + i);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 72'(bus.window_valid), 72'(0));
        chk("midrst_in_ready", 72'(bus.in_ready), 72'(1));
        rst = 1'b0;
        @(negedge clk);
        run(1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
